// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - md_op codes, FSM states and opcode helpers for the multiply/divide unit
package alu_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_md_sign_fix.sv
// rtl/alu_muldiv_md_sign_fix.sv - combinational two's-complement sign correction
// wide_i negates the whole 2*WIDTH value; otherwise each WIDTH half is negated on its own.
module alu_muldiv_md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               wide_i,
  input  logic               neg_hi_i,
  input  logic               neg_lo_i,
  input  logic [2*WIDTH-1:0] val_i,
  output logic [2*WIDTH-1:0] val_o
);

  logic [2*WIDTH-1:0] wide_neg;
  logic [WIDTH-1:0]   hi_half;
  logic [WIDTH-1:0]   lo_half;

  assign wide_neg = -val_i;
  assign hi_half  = neg_hi_i ? -val_i[2*WIDTH-1:WIDTH] : val_i[2*WIDTH-1:WIDTH];
  assign lo_half  = neg_lo_i ? -val_i[WIDTH-1:0] : val_i[WIDTH-1:0];

  assign val_o = wide_i ? (neg_lo_i ? wide_neg : val_i) : {hi_half, lo_half};

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO
// Radix-2: shift-add multiply, restoring divide on magnitudes, signs applied in FIX.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       md_op_i,
  input  logic [WIDTH-1:0] op_x_i,
  input  logic [WIDTH-1:0] op_y_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] x_raw_q;
  logic             is_div_q, neg_hi_q, neg_lo_q, dz_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             neg_x, neg_y;
  logic [W2-1:0]    mag;
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic             sub_ok;
  logic [W2-1:0]    fix_in, fixed;

  assign neg_x = md_is_signed(md_op_i) & op_x_i[WIDTH-1];
  assign neg_y = md_is_signed(md_op_i) & op_y_i[WIDTH-1];

  // mag = {|op_y|, |op_x|}
  alu_muldiv_md_sign_fix #(.WIDTH(WIDTH)) u_mag (
    .wide_i   (1'b0),
    .neg_hi_i (neg_y),
    .neg_lo_i (neg_x),
    .val_i    ({op_y_i, op_x_i}),
    .val_o    (mag)
  );

  assign fix_in = is_div_q ? {rem_q, acc_q[WIDTH-1:0]} : acc_q;

  alu_muldiv_md_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .wide_i   (!is_div_q),
    .neg_hi_i (neg_hi_q),
    .neg_lo_i (neg_lo_q),
    .val_i    (fix_in),
    .val_o    (fixed)
  );

  // Divide keeps the dividend in acc_q low half; quotient bits shift in behind it.
  always_comb begin
    mul_add   = acc_q[0] ? mcand_q : '0;
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mul_add};
    rem_shift = {rem_q, acc_q[WIDTH-1]};
    sub_ok    = rem_shift >= {1'b0, mcand_q};
    if (is_div_q) begin
      rem_d = sub_ok ? rem_shift[WIDTH-1:0] - mcand_q : rem_shift[WIDTH-1:0];
      acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], sub_ok};
    end else begin
      rem_d = rem_q;
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      mcand_q    <= '0;
      x_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_i && !cancel_i) begin
            if (md_is_arith(md_op_i)) begin
              is_div_q   <= md_is_div(md_op_i);
              neg_hi_q   <= neg_x;
              neg_lo_q   <= neg_x ^ neg_y;
              dz_q       <= md_is_div(md_op_i) && (op_y_i == '0);
              x_raw_q    <= op_x_i;
              rem_q      <= '0;
              cnt_q      <= '0;
              div_zero_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= MD_RUN;
              if (md_is_div(md_op_i)) begin
                acc_q   <= {{WIDTH{1'b0}}, mag[WIDTH-1:0]};
                mcand_q <= mag[W2-1:WIDTH];
              end else begin
                acc_q   <= {{WIDTH{1'b0}}, mag[W2-1:WIDTH]};
                mcand_q <= mag[WIDTH-1:0];
              end
            end else if (md_op_i == MD_MTHI) begin
              hi_q <= op_x_i;
            end else if (md_op_i == MD_MTLO) begin
              lo_q <= op_x_i;
            end
          end
        end
        MD_RUN: begin
          if (cancel_i) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_q   <= '0;
              state_q <= MD_FIX;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        MD_FIX: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          if (!cancel_i) begin
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            if (dz_q) begin
              hi_q <= x_raw_q;
              lo_q <= '1;
            end else begin
              hi_q <= fixed[W2-1:WIDTH];
              lo_q <= fixed[WIDTH-1:0];
            end
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench running 32-bit and 16-bit alu_muldiv side by side
// Both instances share stimulus; the 16-bit one sees the low halves of the operands.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel;
  logic [2:0]  md_op;
  logic [31:0] op_x, op_y;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy16, done16, dz16;
  logic [15:0] hi16, lo16;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q32[$];
  exp_t q16[$];
  exp_t m32, m16;
  logic [31:0] m_hi32, m_lo32, m_hi16, m_lo16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_muldiv #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .md_op_i(md_op),
    .op_x_i(op_x), .op_y_i(op_y), .cancel_i(cancel),
    .busy_o(busy32), .done_o(done32), .div_zero_o(dz32), .hi_o(hi32), .lo_o(lo32)
  );

  alu_muldiv #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .md_op_i(md_op),
    .op_x_i(op_x[15:0]), .op_y_i(op_y[15:0]), .cancel_i(cancel),
    .busy_o(busy16), .done_o(done16), .div_zero_o(dz16), .hi_o(hi16), .lo_o(lo16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference results from plain integer arithmetic at width w.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] x,
                                 input logic [31:0] y, input int w);
    exp_t        e;
    logic [63:0] m, ux, uy, up;
    longint      sx, sy, sp, sr;
    m  = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & m;
    uy = {32'd0, y} & m;
    sx = ux[w-1] ? longint'(ux) - (longint'(1) <<< w) : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - (longint'(1) <<< w) : longint'(uy);
    e.hi = '0; e.lo = '0; e.dz = 1'b0; e.cyc = 0;
    case (op)
      MD_MULT: begin
        sp = sx * sy;
        e.hi = 32'((sp >>> w) & m);
        e.lo = 32'(sp & m);
      end
      MD_MULTU: begin
        up = ux * uy;
        e.hi = 32'((up >> w) & m);
        e.lo = 32'(up & m);
      end
      MD_DIV, MD_DIVU: begin
        if (uy == 0) begin
          e.dz = 1'b1; e.hi = 32'(ux); e.lo = 32'(m);
        end else if (op == MD_DIV) begin
          sp = sx / sy; sr = sx % sy;
          e.lo = 32'(sp & m); e.hi = 32'(sr & m);
        end else begin
          e.lo = 32'((ux / uy) & m); e.hi = 32'((ux % uy) & m);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) begin
        chk("done32_unexpected", 32'd1, 32'd0);
      end else begin
        m32 = q32.pop_front();
        chk("hi32", hi32, m32.hi);
        chk("lo32", lo32, m32.lo);
        chk("dz32", {31'd0, dz32}, {31'd0, m32.dz});
        chk("lat32", cyc - m32.cyc, 32'd33);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'd1, 32'd0);
      end else begin
        m16 = q16.pop_front();
        chk("hi16", {16'd0, hi16}, m16.hi);
        chk("lo16", {16'd0, lo16}, m16.lo);
        chk("dz16", {31'd0, dz16}, {31'd0, m16.dz});
        chk("lat16", cyc - m16.cyc, 32'd17);
      end
    end
  end

  task automatic chk_hilo(input string tag);
    chk({tag, "_hi32"}, hi32, m_hi32);
    chk({tag, "_lo32"}, lo32, m_lo32);
    chk({tag, "_hi16"}, {16'd0, hi16}, m_hi16);
    chk({tag, "_lo16"}, {16'd0, lo16}, m_lo16);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy32 || busy16) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, busy32 | busy16}, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain32", q32.size(), 32'd0);
    chk("drain16", q16.size(), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e32, e16;
    wait_idle();
    start = 1'b1; md_op = op; op_x = x; op_y = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (op <= MD_DIVU) begin
      e32 = model(op, x, y, 32); e32.cyc = cyc;
      e16 = model(op, x, y, 16); e16.cyc = cyc;
      q32.push_back(e32); q16.push_back(e16);
      m_hi32 = e32.hi; m_lo32 = e32.lo; m_hi16 = e16.hi; m_lo16 = e16.lo;
    end else begin
      if (op == MD_MTHI) begin m_hi32 = x; m_hi16 = {16'd0, x[15:0]}; end
      if (op == MD_MTLO) begin m_lo32 = x; m_lo16 = {16'd0, x[15:0]}; end
      @(negedge clk);
      chk("mt_busy", {31'd0, busy32 | busy16}, 32'd0);
      chk_hilo("mt");
    end
  endtask

  task automatic issue_cancelled(input logic [2:0] op, input logic [31:0] x);
    wait_idle();
    start = 1'b1; cancel = 1'b1; md_op = op; op_x = x; op_y = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_busy", {31'd0, busy32 | busy16}, 32'd0);
    chk_hilo("cancel_idle");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_8000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; md_op = '0; op_x = '0; op_y = '0;
    m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;
    #12;
    chk("rst_busy", {30'd0, busy32, busy16}, 32'd0);
    chk("rst_done", {30'd0, done32, done16}, 32'd0);
    chk("rst_dz", {30'd0, dz32, dz16}, 32'd0);
    chk_hilo("rst");
    @(negedge clk); rst_n = 1'b1;

    issue(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    issue(MD_DIVU,  32'hFFFF_FFF9, 32'h0000_0002);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(MD_DIVU,  32'h0000_0005, 32'h0000_0000);
    issue(MD_DIV,   32'hFFFF_8000, 32'hFFFF_FFFF);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000);
    issue(MD_DIVU,  32'h0001_0064, 32'h0000_0007);
    wait_drain();

    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    wait_idle();
    start = 1'b1; md_op = MD_MULT; op_x = 32'h0000_1234; op_y = 32'h0000_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("run_busy", {30'd0, busy32, busy16}, 32'd3);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_run_busy", {30'd0, busy32, busy16}, 32'd0);
    chk_hilo("cancel_run");

    issue(MD_MULTU, 32'h0000_0064, 32'h0000_0007);
    repeat (3) @(negedge clk);
    chk("busy_hold", {30'd0, busy32, busy16}, 32'd3);
    start = 1'b1; md_op = MD_DIV; op_x = 32'h7777_7777; op_y = 32'h0000_0003;
    repeat (3) @(negedge clk);
    md_op = MD_MTHI;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    chk_hilo("after_ignored");

    issue(MD_MTLO, 32'hCAFE_BABE, 32'd0);
    issue_cancelled(MD_MTHI, 32'hDEAD_BEEF);
    issue_cancelled(MD_DIVU, 32'h0000_0100);
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    issue(3'd7, 32'h3333_3333, 32'h4444_4444);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end
    wait_drain();

    issue(MD_DIV, 32'h7FFF_FFFF, 32'h0000_0003);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {30'd0, busy32, busy16}, 32'd0);
    chk("arst_done", {30'd0, done32, done16}, 32'd0);
    chk("arst_dz", {30'd0, dz32, dz16}, 32'd0);
    q32.delete(); q16.delete();
    m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;
    chk_hilo("arst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_hilo("post_rst");
    chk("post_rst_busy", {30'd0, busy32, busy16}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
